// File: rtl/ff_seq_detect.sv
// rtl/ff_seq_detect.sv - overlapping 1011 serial pattern detector with saturating match counter
module ff_seq_detect #(
  parameter int          CNT_W  = 8,
  parameter logic [19:0] ID_NUM = 20'd165166
) (
  input  logic             clk,
  input  logic             clear0,
  input  logic             en,
  input  logic             ip0,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             count_full,
  output logic [1:0]       state,
  output logic [19:0]      id_num
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    S10  = 2'd2,
    S101 = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q;
  state_t           state_d;
  logic             det_d;
  logic             match_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             full_q;
  logic             full_d;

  // State register plus the registered copies of match/count/full; clear0 wins over everything
  always_ff @(posedge clk) begin
    if (!clear0) begin
      state_q <= IDLE;
      match_q <= 1'b0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= det_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  // Next-state logic: advance only on enabled samples; S101 + 1 is the detection edge
  always_comb begin
    state_d = state_q;
    det_d   = 1'b0;
    if (en) begin
      case (state_q)
        IDLE: state_d = ip0 ? S1 : IDLE;
        S1:   state_d = ip0 ? S1 : S10;
        S10:  state_d = ip0 ? S101 : IDLE;
        S101: begin
          if (ip0) begin
            // overlap: the final 1 of this match is the first 1 of the next
            state_d = S1;
            det_d   = 1'b1;
          end else begin
            // trailing "10" is already a valid prefix
            state_d = S10;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic: next counter value (clear beats increment, saturate at max) and its full flag
  always_comb begin
    count_d = count_q;
    if (cnt_clr) begin
      count_d = '0;
    end else if (det_d && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end
    full_d = (count_d == CNT_MAX);
  end

  assign match       = match_q;
  assign match_count = count_q;
  assign count_full  = full_q;
  assign state       = state_q;
  assign id_num      = ID_NUM;

endmodule

// File: tb/tb_ff_seq_detect.sv
// tb/tb_ff_seq_detect.sv - self-checking bench for ff_seq_detect against a suffix-matching model
module tb_ff_seq_detect;

  logic       clk;
  logic       clear0;
  logic       en;
  logic       ip0;
  logic       cnt_clr;

  logic       match8;
  logic [7:0] count8;
  logic       full8;
  logic [1:0] state8;
  logic [19:0] id8;

  logic       match2;
  logic [1:0] count2;
  logic       full2;
  logic [1:0] state2;
  logic [19:0] id2;

  int errors;
  int checks;

  // model: last up-to-4 enabled bits since reset, newest in bit 0
  int m_hist;
  int m_n;
  int m_cnt8;
  int m_cnt2;
  bit m_match;
  bit m_full8;
  bit m_full2;

  ff_seq_detect dut8 (
    .clk(clk), .clear0(clear0), .en(en), .ip0(ip0), .cnt_clr(cnt_clr),
    .match(match8), .match_count(count8), .count_full(full8),
    .state(state8), .id_num(id8)
  );

  ff_seq_detect #(.CNT_W(2)) dut2 (
    .clk(clk), .clear0(clear0), .en(en), .ip0(ip0), .cnt_clr(cnt_clr),
    .match(match2), .match_count(count2), .count_full(full2),
    .state(state2), .id_num(id2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Longest proper suffix of the sample history that is a prefix of 1011
  function automatic int model_state();
    for (int k = 3; k >= 1; k--) begin
      if (m_n >= k && ((m_hist & ((1 << k) - 1)) == (4'b1011 >> (4 - k))))
        return k;
    end
    return 0;
  endfunction

  task automatic model_edge();
    bit det;
    if (!clear0) begin
      m_hist = 0; m_n = 0; m_match = 0;
      m_cnt8 = 0; m_cnt2 = 0; m_full8 = 0; m_full2 = 0;
    end else begin
      det = 0;
      if (en) begin
        m_hist = ((m_hist << 1) | int'(ip0)) & 15;
        if (m_n < 4) m_n++;
        det = (m_n >= 4) && (m_hist == 4'b1011);
      end
      m_match = det;
      if (cnt_clr) begin
        m_cnt8 = 0; m_cnt2 = 0;
      end else if (det) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      m_full8 = (m_cnt8 == 255);
      m_full2 = (m_cnt2 == 3);
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("state8", int'(state8), model_state());
    chk("state2", int'(state2), model_state());
    chk("match8", int'(match8), int'(m_match));
    chk("match2", int'(match2), int'(m_match));
    chk("count8", int'(count8), m_cnt8);
    chk("count2", int'(count2), m_cnt2);
    chk("full8", int'(full8), int'(m_full8));
    chk("full2", int'(full2), int'(m_full2));
    chk("id8", int'(id8), 165166);
    chk("id2", int'(id2), 165166);
  endtask

  task automatic step(input logic c0, input logic e, input logic b, input logic cc);
    @(negedge clk);
    clear0 = c0; en = e; ip0 = b; cnt_clr = cc;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic feed(input logic b);
    step(1'b1, 1'b1, b, 1'b0);
  endtask

  initial begin
    errors = 0; checks = 0;
    m_hist = 0; m_n = 0; m_cnt8 = 0; m_cnt2 = 0;
    m_match = 0; m_full8 = 0; m_full2 = 0;
    clear0 = 1'b0; en = 1'b1; ip0 = 1'b0; cnt_clr = 1'b0;

    // reset with ip0 toggling and en high
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("reset_state", int'(state8), 0);

    // basic + overlap: 1011011
    feed(1); feed(0); feed(1); feed(1); feed(0); feed(1); feed(1);
    chk("overlap_count", int'(count8), 2);

    // clear0 pulse between edges must not act
    #2; clear0 = 1'b0; #2; clear0 = 1'b1;
    #1;
    check_all();

    // non-matches: 11001010 ends in S10
    feed(1); feed(1); feed(0); feed(0); feed(1); feed(0); feed(1); feed(0);
    chk("nonmatch_state", int'(state8), 2);

    // enable gating: 1,0,(en=0),1,1
    step(1'b0, 1'b1, 1'b0, 1'b0);
    feed(1); feed(0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    feed(1); feed(1);
    chk("gated_match", int'(match8), 1);
    feed(0); feed(1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("hold_state", int'(state8), 3);

    // saturation on the 2-bit counter: 5 detections, then cnt_clr on a detection edge
    step(1'b0, 1'b1, 1'b0, 1'b0);
    feed(1); feed(0); feed(1); feed(1);
    for (int i = 0; i < 4; i++) begin
      feed(0); feed(1); feed(1);
    end
    chk("sat_count2", int'(count2), 3);
    feed(0); feed(1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr_match", int'(match2), 1);
    chk("clr_count2", int'(count2), 0);

    // reset mid-pattern
    step(1'b0, 1'b1, 1'b0, 1'b0);
    feed(1); feed(0); feed(1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("midreset_state", int'(state8), 0);
    feed(1); feed(0); feed(1); feed(1);
    chk("midreset_count", int'(count8), 1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) != 0), ($urandom_range(0, 7) != 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ff_seq_detect.md
Name: ff_seq_detect

Overview:
Downstream consumer of the AND-gated flip-flop stage. It samples that stage's registered op0 output as a serial bit stream and detects the overlapping pattern 1011 with a Moore/Mealy-registered FSM. It emits a one-cycle match pulse and keeps a saturating count of detections. It reports a fixed 20-bit ID on id_num, like the upstream stage.

Parameters:
CNT_W, 8, width of the detection counter match_count
ID_NUM, 20'd165166, constant driven on id_num

Ports:
clk  input  1  system clock; all state updates on rising edge
clear0  input  1  synchronous active-low reset; sampled on rising edge of clk
en  input  1  sample enable; ip0 consumed only on an edge where en=1
ip0  input  1  serial data bit (connects to upstream op0)
cnt_clr  input  1  synchronous clear of match_count only
match  output  1  registered one-cycle pulse per detected 1011
match_count  output  CNT_W  saturating number of detections
count_full  output  1  high while match_count == 2^CNT_W-1
state  output  2  current FSM state (debug): 0=IDLE, 1=S1, 2=S10, 3=S101
id_num  output  20  constant ID_NUM, independent of clock and reset

Behaviour:
- Reset: on a rising edge with clear0=0, next values are state=IDLE(0), match=0, match_count=0, count_full=0. Reset is synchronous only; a clear0 pulse between edges has no effect. clear0 has priority over every other input.
- Every output except id_num is a flop output, so there is no combinational path from inputs to outputs.
- en=0 at an edge: state and match_count hold; match<=0.
- en=1 at an edge: FSM transition on ip0:
  - IDLE: ip0=1 -> S1; ip0=0 -> IDLE
  - S1: ip0=0 -> S10; ip0=1 -> S1
  - S10: ip0=1 -> S101; ip0=0 -> IDLE
  - S101: ip0=1 -> S1 with a detection (overlap keeps the trailing 1); ip0=0 -> S10 (the suffix 10 is kept)
- Detection latency: match is high for exactly the one cycle after the edge that sampled the final 1. Back-to-back detections are possible, e.g. 1011011 gives two pulses 3 enabled samples apart.
- Counter:
  - On a detection edge, match_count <= match_count+1 unless it is already at 2^CNT_W-1, in which case it holds (saturates, no wrap).
  - count_full is registered and tracks the next match_count value (high from the same edge at which the count reaches max).
- cnt_clr=1 (with clear0=1): match_count<=0 and count_full<=0 regardless of detection. FSM and match still update normally, so a simultaneous detection still pulses match but does not increment.
- Reset mid-pattern: partial progress (S1/S10/S101) is discarded; detection restarts from IDLE on the next enabled sample.
- ip0 is assumed synchronous to clk (the upstream flop shares clk); no synchronizer is included.

Test Plan:
- Reset: hold clear0=0 for 2 edges with ip0 toggling and en=1 -> state=0, match=0, match_count=0, count_full=0. Pulse clear0 low between edges only -> no change.
- Basic and overlap: en=1, ip0 sequence 1,0,1,1,0,1,1 -> state sequence 1,2,3,1,2,3,1; match high in the cycle after the 4th and 7th samples; match_count=2.
- Non-matches: ip0 sequence 1,1,0,0,1,0,1,0 -> no match. State after the last sample = 2 (S10, from the 1010 suffix).
- Enable gating: feed 1,0,1,1 with en=0 on the cycle between the 2nd and 3rd bits (ip0 driven 0 there) -> still exactly one match. Then en=0 with ip0=1 while in S101 -> state holds at 3, match stays 0.
- Saturation and clear: CNT_W=2, feed 5 detections -> match_count = 1,2,3,3,3, with count_full rising at the 3rd detection edge. Then assert cnt_clr on a detection edge -> match=1, match_count=0, count_full=0.
- Reset mid-operation: after 1,0,1 (state=3), assert clear0=0 for one edge while ip0=1 -> state=0, no match. Next enabled samples 1,0,1,1 -> one match, match_count=1.
